// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler
//   Round-robin write scheduler and read sequencer wrapped around one FifoSync.
//   NUM_REQ producers are arbitrated onto the FIFO write port. Occupancy is
//   tracked here because the FIFO has no flags. The FIFO read port is turned
//   into a registered valid/ready output stream.
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_data    producer words, producer i at [i*DATA_W +: DATA_W]
//   req_ready, grant_id   one-hot grant and index of the granted producer
//   fifo_wen/fifo_wdata   FifoSync write port
//   fifo_ren/fifo_rdata   FifoSync read port (rdata valid 1 cycle after ren)
//   out_valid/out_data    registered output word, taken on out_valid&out_ready
//   level, full, empty    words held inside the FIFO (out_data not counted)
module fifo_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int IDW     = $clog2(NUM_REQ),
  parameter int LW      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [IDW-1:0]            grant_id,
  output logic                      fifo_wen,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic                      fifo_ren,
  input  logic [DATA_W-1:0]         fifo_rdata,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [LW-1:0]             level,
  output logic                      full,
  output logic                      empty
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} rd_state_t;

  rd_state_t           state_r, state_nxt_s;
  logic [LW-1:0]       level_r;
  logic [IDW-1:0]      rr_last_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;

  logic                full_s;
  logic                grant_found_s;
  logic [IDW-1:0]      grant_idx_s;
  logic [IDW-1:0]      cand_s;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic                fifo_ren_s;

  assign full_s = (level_r == LW'(DEPTH));

  // Round-robin search starting just after the last granted producer.
  // Grants are suppressed under reset so nothing is written during it.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    req_ready_s   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDW'((int'(rr_last_r) + k) % NUM_REQ);
      if (!grant_found_s && !reset && !full_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    if (grant_found_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Read sequencer next state; fifo_ren only fires when the FIFO holds a word,
  // and a write landing in the same cycle is deliberately not counted.
  always_comb begin
    state_nxt_s = state_r;
    fifo_ren_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!reset && (level_r != '0)) begin
          fifo_ren_s  = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        state_nxt_s = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (!reset && (level_r != '0)) begin
            fifo_ren_s  = 1'b1;
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, occupancy, round-robin pointer and output word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      level_r     <= '0;
      rr_last_r   <= IDW'(NUM_REQ - 1);
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      case ({grant_found_s, fifo_ren_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      if (grant_found_s) begin
        rr_last_r <= grant_idx_s;
      end else begin
        rr_last_r <= rr_last_r;
      end
      case (state_r)
        WAIT: begin
          out_data_r  <= fifo_rdata;
          out_valid_r <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        default: begin
          out_valid_r <= out_valid_r;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign grant_id   = grant_idx_s;
  assign fifo_wen   = grant_found_s;
  assign fifo_wdata = req_data[grant_idx_s*DATA_W +: DATA_W];
  assign fifo_ren   = fifo_ren_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign level      = level_r;
  assign full       = full_s;
  assign empty      = (level_r == '0);

endmodule

// fifo_rr_scheduler_chk
//   Property checker for fifo_rr_scheduler occupancy and grant rules.
// Ports
//   clk, reset, level, full, fifo_wen, fifo_ren, req_ready (all observed only)
module fifo_rr_scheduler_chk #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 16,
  parameter int LW      = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               reset,
  input logic [LW-1:0]      level,
  input logic               full,
  input logic               fifo_wen,
  input logic               fifo_ren,
  input logic [NUM_REQ-1:0] req_ready
);

  a_level_max: assert property (@(posedge clk) disable iff (reset) level <= LW'(DEPTH));
  a_no_ren_empty: assert property (@(posedge clk) disable iff (reset) !(fifo_ren && (level == '0)));
  a_no_wen_full: assert property (@(posedge clk) disable iff (reset) !(fifo_wen && full));
  a_onehot_grant: assert property (@(posedge clk) $onehot0(req_ready));

endmodule
